// File: rtl/gb_mbc1_rom_bridge_if.sv
// -----------------------------------------------------------------------------
// gb_mbc1_rom_bridge_if
// Bus bundle between the MBC1 ROM bridge and its surroundings.
//   load_done                         loader finished, SPRAM ownership handover
//   ld_spram_addr/we/cs/d             loader-side SPRAM write port
//   spram_addr/we/cs/d, spram_q       physical SPRAM port (q: 1 clk read latency)
//   gb_addr/rd_n/wr_n/d_in            raw (asynchronous) Game Boy cartridge bus
//   gb_d_out/gb_d_oe                  byte and output enable returned to the GB
// modport slave  : the bridge's view
// modport master : the environment's view (loader, SPRAM, GB bus)
// -----------------------------------------------------------------------------
interface gb_mbc1_rom_bridge_if;
   logic        load_done;
   logic [15:0] ld_spram_addr;
   logic        ld_spram_we;
   logic        ld_spram_cs;
   logic [15:0] ld_spram_d;
   logic [15:0] spram_addr;
   logic        spram_we;
   logic        spram_cs;
   logic [15:0] spram_d;
   logic [15:0] spram_q;
   logic [15:0] gb_addr;
   logic        gb_rd_n;
   logic        gb_wr_n;
   logic [7:0]  gb_d_in;
   logic [7:0]  gb_d_out;
   logic        gb_d_oe;

   modport slave (
      input  load_done, ld_spram_addr, ld_spram_we, ld_spram_cs, ld_spram_d,
      input  spram_q, gb_addr, gb_rd_n, gb_wr_n, gb_d_in,
      output spram_addr, spram_we, spram_cs, spram_d, gb_d_out, gb_d_oe
   );

   modport master (
      output load_done, ld_spram_addr, ld_spram_we, ld_spram_cs, ld_spram_d,
      output spram_q, gb_addr, gb_rd_n, gb_wr_n, gb_d_in,
      input  spram_addr, spram_we, spram_cs, spram_d, gb_d_out, gb_d_oe
   );
endinterface

// File: rtl/gb_mbc1_rom_bridge.sv
// -----------------------------------------------------------------------------
// gb_mbc1_rom_bridge
// Serves Game Boy cartridge ROM reads (0x0000-0x7FFF) out of a 16-bit SPRAM
// and implements MBC1 ROM banking. Until load_done the loader's SPRAM port is
// passed straight through; afterwards this block owns the SPRAM (read only).
// Parameters:
//   ROM_BANKS  number of 16 KiB banks present (2, 4 or 8)
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset
//   bus        gb_mbc1_rom_bridge_if.slave (loader, SPRAM and GB bus signals)
// -----------------------------------------------------------------------------
module gb_mbc1_rom_bridge #(
   parameter int ROM_BANKS = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   gb_mbc1_rom_bridge_if.slave   bus
);

   localparam int B = $clog2(ROM_BANKS);

   typedef enum logic [1:0] {
      ST_WAIT_LOAD = 2'd0,
      ST_IDLE      = 2'd1,
      ST_FETCH     = 2'd2,
      ST_CAPTURE   = 2'd3
   } state_t;

   // synchroniser stages (_m = metastable first stage, _s = synced copy)
   logic [15:0] addr_m, addr_s;
   logic        rd_n_m, rd_n_s;
   logic        wr_n_m, wr_n_s;
   logic [7:0]  d_in_m, d_in_s;

   logic        wr_n_d_r;
   logic [7:0]  wdat_r;
   logic        wr_rise_s;

   logic [4:0]  bank_lo_r;
   logic [1:0]  bank_hi_r;
   logic        mode_r;
   logic        commit_r;

   logic [6:0]  bank_s;
   logic [B+13:0] byte_addr_s;
   logic [15:0] word_addr_s;
   logic        byte_sel_s;

   state_t      state_r, state_nx;
   logic        fetch_cs_s;
   logic        fetch_sel_r;
   logic [15:0] last_word_r;
   logic        last_sel_r;
   logic [7:0]  gb_d_out_r;
   logic        gb_d_oe_r;

   // bank bits above the ROM size and unused data bits are intentionally dropped
   logic        unused_bits_s;
   assign unused_bits_s = ^{bank_s, wdat_r[7:5]};

   // Two-flop synchronisers for the asynchronous GB bus
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr_m <= 16'h0000;
         addr_s <= 16'h0000;
         rd_n_m <= 1'b1;
         rd_n_s <= 1'b1;
         wr_n_m <= 1'b1;
         wr_n_s <= 1'b1;
         d_in_m <= 8'h00;
         d_in_s <= 8'h00;
      end else begin
         addr_m <= bus.gb_addr;
         addr_s <= addr_m;
         rd_n_m <= bus.gb_rd_n;
         rd_n_s <= rd_n_m;
         wr_n_m <= bus.gb_wr_n;
         wr_n_s <= wr_n_m;
         d_in_m <= bus.gb_d_in;
         d_in_s <= d_in_m;
      end
   end

   // Write strobe history and last data byte seen while the strobe was low
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_n_d_r <= 1'b1;
         wdat_r   <= 8'h00;
      end else begin
         wr_n_d_r <= wr_n_s;
         if (!wr_n_s) begin
            wdat_r <= d_in_s;
         end
      end
   end

   assign wr_rise_s = wr_n_s & ~wr_n_d_r;

   // MBC1 bank registers; commit_r flags a committed register write for one clk
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bank_lo_r <= 5'd1;
         bank_hi_r <= 2'd0;
         mode_r    <= 1'b0;
         commit_r  <= 1'b0;
      end else begin
         commit_r <= 1'b0;
         if (wr_rise_s && !addr_s[15]) begin
            case (addr_s[14:13])
               2'b01: begin
                  // MBC1 quirk: bank 0 cannot be selected in the switchable window
                  bank_lo_r <= (wdat_r[4:0] == 5'd0) ? 5'd1 : wdat_r[4:0];
                  commit_r  <= 1'b1;
               end
               2'b10: begin
                  bank_hi_r <= wdat_r[1:0];
                  commit_r  <= 1'b1;
               end
               2'b11: begin
                  mode_r   <= wdat_r[0];
                  commit_r <= 1'b1;
               end
               default: begin
                  // RAM enable region: no ROM-side effect
               end
            endcase
         end
      end
   end

   // GB address -> SPRAM word address and byte lane; truncation to B bits gives the modulo
   always_comb begin
      bank_s = 7'd0;
      if (addr_s[14]) begin
         bank_s = {bank_hi_r, bank_lo_r};
      end else if (mode_r) begin
         bank_s = {bank_hi_r, 5'd0};
      end else begin
         bank_s = 7'd0;
      end
      byte_addr_s = {bank_s[B-1:0], addr_s[13:0]};
      word_addr_s = 16'(byte_addr_s[B+13:1]);
      byte_sel_s  = byte_addr_s[0];
   end

   // FSM next state and SPRAM chip select
   always_comb begin
      state_nx   = state_r;
      fetch_cs_s = 1'b0;
      if (!bus.load_done) begin
         state_nx = ST_WAIT_LOAD;
      end else begin
         case (state_r)
            ST_WAIT_LOAD: state_nx = ST_FETCH;
            ST_IDLE: begin
               if ((word_addr_s != last_word_r) || (byte_sel_s != last_sel_r) || commit_r) begin
                  state_nx = ST_FETCH;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
            ST_FETCH: begin
               fetch_cs_s = 1'b1;
               state_nx   = ST_CAPTURE;
            end
            ST_CAPTURE: state_nx = ST_IDLE;
            default:    state_nx = ST_WAIT_LOAD;
         endcase
      end
   end

   // FSM state, fetched-address bookkeeping and registered GB outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r     <= ST_WAIT_LOAD;
         fetch_sel_r <= 1'b0;
         last_word_r <= 16'h0000;
         last_sel_r  <= 1'b0;
         gb_d_out_r  <= 8'h00;
         gb_d_oe_r   <= 1'b0;
      end else begin
         state_r <= state_nx;
         if (state_r == ST_FETCH) begin
            // remember what was actually issued; addr_s may move before CAPTURE
            fetch_sel_r <= byte_sel_s;
            last_word_r <= word_addr_s;
         end
         if (state_r == ST_CAPTURE) begin
            gb_d_out_r <= fetch_sel_r ? bus.spram_q[15:8] : bus.spram_q[7:0];
            last_sel_r <= fetch_sel_r;
         end
         // a simultaneous write strobe suppresses the drive
         gb_d_oe_r <= bus.load_done & ~rd_n_s & wr_n_s & ~addr_s[15];
      end
   end

   // SPRAM ownership mux: loader before load_done, read-only FSM afterwards
   always_comb begin
      if (bus.load_done) begin
         bus.spram_addr = word_addr_s;
         bus.spram_we   = 1'b0;
         bus.spram_cs   = fetch_cs_s;
         bus.spram_d    = 16'h0000;
      end else begin
         bus.spram_addr = bus.ld_spram_addr;
         bus.spram_we   = bus.ld_spram_we;
         bus.spram_cs   = bus.ld_spram_cs;
         bus.spram_d    = bus.ld_spram_d;
      end
   end

   assign bus.gb_d_out = gb_d_out_r;
   assign bus.gb_d_oe  = gb_d_oe_r;

endmodule

// File: tb/tb_gb_mbc1_rom_bridge.sv
// -----------------------------------------------------------------------------
// tb_gb_mbc1_rom_bridge
// Self-checking bench: directed sequences, a table of banking vectors and
// randomized GB bus traffic checked against an arithmetic MBC1 reference model.
// -----------------------------------------------------------------------------
module tb_gb_mbc1_rom_bridge;
   localparam int ROM_BANKS = 8;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   gb_mbc1_rom_bridge_if bus();

   gb_mbc1_rom_bridge #(.ROM_BANKS(ROM_BANKS)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- SPRAM model (pattern-filled, 1 clk read latency) ----------
   logic [15:0] mem     [0:65535];
   bit          written [0:65535];

   function automatic logic [15:0] pat(input logic [15:0] a);
      return (a * 16'd40503) ^ 16'h9E37;
   endfunction

   always @(posedge clk) begin
      if (bus.spram_cs) begin
         if (bus.spram_we) begin
            mem[bus.spram_addr]     <= bus.spram_d;
            written[bus.spram_addr] <= 1'b1;
         end else begin
            bus.spram_q <= written[bus.spram_addr] ? mem[bus.spram_addr] : pat(bus.spram_addr);
         end
      end
   end

   // last word address the bridge actually fetched
   logic [15:0] seen_addr = 16'h0000;
   always @(negedge clk) begin
      if (bus.load_done && bus.spram_cs) seen_addr <= bus.spram_addr;
   end

   // ---------------- reference model ----------------
   int m_lo = 1, m_hi = 0, m_mode = 0;
   logic [15:0] ref_ld [int];

   function automatic logic [15:0] ref_word(input int w);
      if (ref_ld.exists(w)) return ref_ld[w];
      return pat(16'(w));
   endfunction

   function automatic int exp_index(input int a);
      int bank;
      if (a < 16384) bank = m_mode ? m_hi * 32 : 0;
      else           bank = m_hi * 32 + m_lo;
      return (bank % ROM_BANKS) * 16384 + (a % 16384);
   endfunction

   function automatic logic [7:0] exp_byte(input int a);
      int idx;
      logic [15:0] w;
      idx = exp_index(a);
      w   = ref_word(idx / 2);
      return (idx % 2 == 1) ? w[15:8] : w[7:0];
   endfunction

   task automatic model_write(input int a, input int v);
      if (a < 32768) begin
         case (a / 8192)
            1: m_lo   = (v % 32 == 0) ? 1 : v % 32;
            2: m_hi   = v % 4;
            3: m_mode = v % 2;
            default: ;
         endcase
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- GB bus tasks ----------------
   task automatic gb_read(input logic [15:0] a, output logic [7:0] dout,
                          output logic oe, output logic [15:0] word);
      @(posedge clk); #1;
      bus.gb_addr = a;
      bus.gb_rd_n = 1'b0;
      bus.gb_wr_n = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      dout = bus.gb_d_out;
      oe   = bus.gb_d_oe;
      word = seen_addr;
      @(posedge clk); #1;
      bus.gb_rd_n = 1'b1;
   endtask

   task automatic gb_write(input logic [15:0] a, input logic [7:0] v);
      @(posedge clk); #1;
      bus.gb_addr = a;
      bus.gb_d_in = v;
      bus.gb_rd_n = 1'b1;
      bus.gb_wr_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 bus.gb_wr_n = 1'b1;
      repeat (6) @(posedge clk);
      model_write(int'(a), int'(v));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          is_wr;
      logic [15:0] addr;
      logic [7:0]  data;
      bit          chk_word;
      logic [15:0] exp_word;
      bit          exp_oe;
   } vec_t;

   vec_t vt [16];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : main
      logic [7:0]  d;
      logic        oe;
      logic [15:0] w;
      bit          fetching;

      vt[0]  = '{1'b1, 16'h2000, 8'h03, 1'b0, 16'h0000, 1'b0};
      vt[1]  = '{1'b0, 16'h4000, 8'h00, 1'b1, 16'h6000, 1'b1};
      vt[2]  = '{1'b1, 16'h2100, 8'h00, 1'b0, 16'h0000, 1'b0};
      vt[3]  = '{1'b0, 16'h4002, 8'h00, 1'b1, 16'h2001, 1'b1};
      vt[4]  = '{1'b1, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0};
      vt[5]  = '{1'b0, 16'h4002, 8'h00, 1'b1, 16'h2001, 1'b1};
      vt[6]  = '{1'b1, 16'h2000, 8'h1F, 1'b0, 16'h0000, 1'b0};
      vt[7]  = '{1'b0, 16'h7FFF, 8'h00, 1'b1, 16'hFFFF, 1'b1};
      vt[8]  = '{1'b0, 16'hA000, 8'h00, 1'b0, 16'h0000, 1'b0};
      vt[9]  = '{1'b1, 16'h4000, 8'h01, 1'b0, 16'h0000, 1'b0};
      vt[10] = '{1'b1, 16'h6000, 8'h01, 1'b0, 16'h0000, 1'b0};
      vt[11] = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b1};
      vt[12] = '{1'b0, 16'h4000, 8'h00, 1'b1, 16'hE000, 1'b1};
      vt[13] = '{1'b1, 16'h2000, 8'h20, 1'b0, 16'h0000, 1'b0};
      vt[14] = '{1'b0, 16'h4000, 8'h00, 1'b1, 16'h2000, 1'b1};
      vt[15] = '{1'b1, 16'h6000, 8'h00, 1'b0, 16'h0000, 1'b0};

      reset_n           = 1'b0;
      bus.load_done     = 1'b0;
      bus.ld_spram_addr = 16'h0000;
      bus.ld_spram_we   = 1'b0;
      bus.ld_spram_cs   = 1'b0;
      bus.ld_spram_d    = 16'h0000;
      bus.gb_addr       = 16'h0000;
      bus.gb_rd_n       = 1'b1;
      bus.gb_wr_n       = 1'b1;
      bus.gb_d_in       = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_d_out", 32'(bus.gb_d_out), 32'h00);
      chk("reset_oe", 32'(bus.gb_d_oe), 32'h0);
      reset_n = 1'b1;

      // loader passthrough, same cycle
      @(posedge clk); #1;
      bus.ld_spram_addr = 16'h1234;
      bus.ld_spram_d    = 16'hCAFE;
      bus.ld_spram_we   = 1'b1;
      bus.ld_spram_cs   = 1'b1;
      bus.gb_addr       = 16'h0000;
      bus.gb_rd_n       = 1'b0;
      #1;
      chk("pass_addr", 32'(bus.spram_addr), 32'h1234);
      chk("pass_we", 32'(bus.spram_we), 32'h1);
      chk("pass_cs", 32'(bus.spram_cs), 32'h1);
      chk("pass_d", 32'(bus.spram_d), 32'hCAFE);
      ref_ld[16'h1234] = 16'hCAFE;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("preload_oe", 32'(bus.gb_d_oe), 32'h0);
      @(posedge clk); #1;
      bus.ld_spram_addr = 16'h0000;
      bus.ld_spram_d    = 16'hBBAA;
      ref_ld[0] = 16'hBBAA;
      @(posedge clk); #1;
      bus.ld_spram_we = 1'b0;
      bus.ld_spram_cs = 1'b0;
      bus.gb_rd_n     = 1'b1;

      // ownership handover
      @(posedge clk); #1;
      bus.load_done = 1'b1;
      #1;
      chk("own_we", 32'(bus.spram_we), 32'h0);
      chk("own_d", 32'(bus.spram_d), 32'h0);
      gb_read(16'h0001, d, oe, w);
      chk("rd0001_data", 32'(d), 32'hBB);
      chk("rd0001_oe", 32'(oe), 32'h1);
      gb_read(16'h0000, d, oe, w);
      chk("rd0000_data", 32'(d), 32'hAA);

      // read and write strobes both low: no drive, RAM-enable write ignored
      @(posedge clk); #1;
      bus.gb_addr = 16'h0000;
      bus.gb_d_in = 8'h00;
      bus.gb_rd_n = 1'b0;
      bus.gb_wr_n = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rdwr_oe", 32'(bus.gb_d_oe), 32'h0);
      bus.gb_wr_n = 1'b1;
      bus.gb_rd_n = 1'b1;
      repeat (6) @(posedge clk);

      // table of banking vectors
      for (int i = 0; i < 16; i++) begin
         if (vt[i].is_wr) begin
            gb_write(vt[i].addr, vt[i].data);
         end else begin
            gb_read(vt[i].addr, d, oe, w);
            chk($sformatf("vec%0d_oe", i), 32'(oe), 32'(vt[i].exp_oe));
            if (vt[i].chk_word) begin
               chk($sformatf("vec%0d_word", i), 32'(w), 32'(vt[i].exp_word));
               chk($sformatf("vec%0d_data", i), 32'(d), 32'(exp_byte(int'(vt[i].addr))));
            end
         end
      end

      // randomized traffic against the reference model
      for (int i = 0; i < 200; i++) begin
         int a;
         a = int'($urandom_range(0, 65535));
         if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 7) != 0) a = a % 32768;
            gb_write(16'(a), 8'($urandom));
         end else begin
            gb_read(16'(a), d, oe, w);
            chk("rnd_oe", 32'(oe), (a < 32768) ? 32'h1 : 32'h0);
            if (a < 32768) begin
               chk("rnd_word", 32'(w), 32'(exp_index(a) / 2));
               chk("rnd_data", 32'(d), 32'(exp_byte(a)));
            end
         end
      end

      // reset during a fetch
      gb_write(16'h2000, 8'h05);
      @(posedge clk); #1;
      bus.gb_addr = 16'h4000;
      bus.gb_rd_n = 1'b0;
      fetching = 1'b0;
      for (int i = 0; i < 20 && !fetching; i++) begin
         @(negedge clk);
         fetching = bus.spram_cs;
      end
      chk("fetch_seen", 32'(fetching), 32'h1);
      reset_n       = 1'b0;
      bus.load_done = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_lo = 1; m_hi = 0; m_mode = 0;
      @(negedge clk);
      chk("rst_fetch_oe", 32'(bus.gb_d_oe), 32'h0);
      chk("rst_fetch_dout", 32'(bus.gb_d_out), 32'h00);
      repeat (3) @(posedge clk);
      #1 bus.load_done = 1'b1;
      gb_read(16'h4000, d, oe, w);
      chk("reload_word", 32'(w), 32'h2000);
      chk("reload_data", 32'(d), 32'(exp_byte(16'h4000)));
      chk("reload_oe", 32'(oe), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
